// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: press/release FSM over the debounced key vector,
// 4-digit BCD entry buffer with backspace/clear/enter, and multiplexed display scan.
module keypad_entry_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_deb,
  output logic [15:0] disp_data,
  output logic [2:0]  digit_count,
  output logic        commit_valid,
  output logic [15:0] commit_value,
  output logic [3:0]  scan_cs,
  output logic [3:0]  scan_nibble,
  output logic        scan_blank
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned KEY_N   = 16;
  localparam logic [3:0]  KEY_BS  = 4'd10;
  localparam logic [3:0]  KEY_CLR = 4'd11;
  localparam logic [3:0]  KEY_ENT = 4'd12;

  typedef enum logic [1:0] {
    WAIT_PRESS   = 2'd0,
    EXEC         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  state_e             state_q;
  logic [KEY_N-1:0]   key_q;
  logic [3:0]         code_q;
  logic               first_q;
  logic [15:0]        disp_q;
  logic [2:0]         count_q;
  logic               commit_valid_q;
  logic [15:0]        commit_value_q;
  logic [DIV_W-1:0]   div_q;
  logic [1:0]         idx_q;
  logic [3:0]         scan_cs_q;
  logic [3:0]         scan_nibble_q;
  logic               scan_blank_q;

  logic               one_hot_c;
  logic [3:0]         code_c;
  logic               div_wrap_c;
  logic [DIV_W-1:0]   div_d;
  logic [1:0]         idx_d;
  logic [3:0]         nibble_d;
  logic               blank_d;
  logic               release_ok_c;

  // Key decode: exactly-one-hot detect and index of the held key.
  always_comb begin
    one_hot_c = (key_q != '0) && ((key_q & (key_q - KEY_N'(1))) == '0);
    code_c    = 4'd0;
    for (int i = 0; i < KEY_N; i++) begin
      if (key_q[i]) code_c = 4'(i);
    end
  end

  // A key already held when reset drops must not look like a fresh press.
  always_comb begin
    release_ok_c = (key_q == '0) && !(first_q && (key_deb != '0));
  end

  // Scan divider and next-digit selection.
  always_comb begin
    div_wrap_c = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d      = div_wrap_c ? '0 : div_q + DIV_W'(1);
    idx_d      = div_wrap_c ? idx_q + 2'd1 : idx_q;
    case (idx_d)
      2'd0:    nibble_d = disp_q[3:0];
      2'd1:    nibble_d = disp_q[7:4];
      2'd2:    nibble_d = disp_q[11:8];
      default: nibble_d = disp_q[15:12];
    endcase
    blank_d = ({1'b0, idx_d} >= count_q) && !((idx_d == 2'd0) && (count_q == 3'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_RELEASE;
      key_q          <= '0;
      code_q         <= 4'd0;
      first_q        <= 1'b1;
      disp_q         <= '0;
      count_q        <= 3'd0;
      commit_valid_q <= 1'b0;
      commit_value_q <= '0;
      div_q          <= '0;
      idx_q          <= 2'd0;
      scan_cs_q      <= 4'b1110;
      scan_nibble_q  <= 4'd0;
      scan_blank_q   <= 1'b0;
    end else begin
      key_q          <= key_deb;
      first_q        <= 1'b0;
      commit_valid_q <= 1'b0;
      div_q          <= div_d;
      idx_q          <= idx_d;
      scan_cs_q      <= ~(4'b0001 << idx_d);
      scan_nibble_q  <= nibble_d;
      scan_blank_q   <= blank_d;

      case (state_q)
        WAIT_PRESS: begin
          if (one_hot_c) begin
            code_q  <= code_c;
            state_q <= EXEC;
          end else if (key_q != '0) begin
            state_q <= WAIT_RELEASE;
          end
        end
        EXEC: begin
          state_q <= WAIT_RELEASE;
          if (code_q <= 4'd9) begin
            if (count_q < 3'd4) begin
              disp_q  <= {disp_q[11:0], code_q};
              count_q <= count_q + 3'd1;
            end
          end else if (code_q == KEY_BS) begin
            if (count_q != 3'd0) begin
              disp_q  <= {4'h0, disp_q[15:4]};
              count_q <= count_q - 3'd1;
            end
          end else if (code_q == KEY_CLR) begin
            disp_q  <= '0;
            count_q <= 3'd0;
          end else if (code_q == KEY_ENT) begin
            if (count_q != 3'd0) begin
              commit_value_q <= disp_q;
              commit_valid_q <= 1'b1;
              disp_q         <= '0;
              count_q        <= 3'd0;
            end
          end
        end
        WAIT_RELEASE: begin
          if (release_ok_c) state_q <= WAIT_PRESS;
        end
        default: state_q <= WAIT_RELEASE;
      endcase
    end
  end

  assign disp_data    = disp_q;
  assign digit_count  = count_q;
  assign commit_valid = commit_valid_q;
  assign commit_value = commit_value_q;
  assign scan_cs      = scan_cs_q;
  assign scan_nibble  = scan_nibble_q;
  assign scan_blank   = scan_blank_q;

endmodule
